// File: rtl/key_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : key_event_scheduler
// Description : Queues one pending press event per key and serialises them
//               onto a single valid/ready stream using round-robin grant.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_scheduler #(
  parameter  int KEYS_CNT   = 4,
  parameter  int DROP_CNT_W = 8,
  localparam int KEY_W      = $clog2(KEYS_CNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [KEYS_CNT-1:0]   key_stb_i,
  input  logic [KEYS_CNT-1:0]   key_en_i,
  output logic                  event_valid_o,
  output logic [KEY_W-1:0]      event_key_o,
  input  logic                  event_ready_i,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  input  logic                  drop_clr_i
);

  // Output slot: EMPTY (no event presented) or FULL (event held until ready)
  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  localparam logic [KEY_W-1:0] C_LAST_KEY = KEY_W'(KEYS_CNT - 1);

  slot_e                 slot_q, slot_d;
  logic [KEYS_CNT-1:0]   pending_q, pending_d;
  logic [KEY_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [KEY_W-1:0]      key_q, key_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  load;
  logic                  found;
  logic [KEY_W-1:0]      gnt_idx;
  logic [KEYS_CNT-1:0]   gnt_vec;
  logic [KEYS_CNT-1:0]   drop_vec;

  // Round-robin search of registered pending bits, starting at rr_ptr
  always_comb begin
    int idx;
    found   = 1'b0;
    gnt_idx = rr_ptr_q;
    idx     = 0;
    for (int i = 0; i < KEYS_CNT; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= KEYS_CNT) idx = idx - KEYS_CNT;
      if (!found && pending_q[idx]) begin
        found   = 1'b1;
        gnt_idx = KEY_W'(idx);
      end
    end
  end

  // Slot load decision and the one-hot grant it implies
  always_comb begin
    load    = (slot_q == SLOT_EMPTY) || event_ready_i;
    gnt_vec = '0;
    if (load && found) gnt_vec[gnt_idx] = 1'b1;
  end

  // Per-key pending update and lost-strobe detection
  generate
    for (genvar k = 0; k < KEYS_CNT; k++) begin : g_key
      // A strobe in the grant cycle re-arms the key instead of being lost
      always_comb begin
        pending_d[k] = 1'b0;
        drop_vec[k]  = 1'b0;
        if (key_en_i[k]) begin
          pending_d[k] = (pending_q[k] && !gnt_vec[k]) || key_stb_i[k];
          drop_vec[k]  = key_stb_i[k] && pending_q[k] && !gnt_vec[k];
        end
      end
    end
  endgenerate

  // Output slot next state, presented key and round-robin pointer
  always_comb begin
    slot_d   = slot_q;
    key_d    = key_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      if (found) begin
        slot_d   = SLOT_FULL;
        key_d    = gnt_idx;
        rr_ptr_d = (gnt_idx == C_LAST_KEY) ? '0 : gnt_idx + KEY_W'(1);
      end else begin
        slot_d = SLOT_EMPTY;
      end
    end
  end

  // Saturating drop counter; clear has priority over a same-cycle drop
  always_comb begin
    drop_d = drop_q;
    if (drop_clr_i) begin
      drop_d = '0;
    end else if ((|drop_vec) && !(&drop_q)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q    <= SLOT_EMPTY;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      key_q     <= '0;
      drop_q    <= '0;
    end else begin
      slot_q    <= slot_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      key_q     <= key_d;
      drop_q    <= drop_d;
    end
  end

  assign event_valid_o = (slot_q == SLOT_FULL);
  assign event_key_o   = key_q;
  assign drop_cnt_o    = drop_q;

endmodule
`default_nettype wire
